// File: rtl/lsu_ecc_scrub_wr.sv
// DCCM ECC scrub write-back: queues single-bit-corrected doublewords
// and rewrites them with fresh SECDED check bits via a req/gnt port.
module lsu_ecc_scrub_wr #(
    parameter int DATA_WIDTH = 64,
    parameter int ECC_WIDTH  = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            sec_lo_valid,
    input  logic [ADDR_WIDTH-1:0]           sec_lo_addr,
    input  logic [DATA_WIDTH-1:0]           sec_lo_data,
    input  logic                            sec_hi_valid,
    input  logic [ADDR_WIDTH-1:0]           sec_hi_addr,
    input  logic [DATA_WIDTH-1:0]           sec_hi_data,
    input  logic                            stbuf_wr_valid,
    input  logic [ADDR_WIDTH-1:0]           stbuf_wr_addr,
    input  logic                            ecc_disable,
    output logic                            dccm_scrub_req,
    output logic [ADDR_WIDTH-1:0]           dccm_scrub_addr,
    output logic [DATA_WIDTH+ECC_WIDTH-1:0] dccm_scrub_wdata,
    input  logic                            dccm_scrub_gnt,
    output logic                            scrub_ovf,
    output logic                            scrub_busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = ADDR_WIDTH - 3;

    typedef enum logic {S_IDLE, S_REQ} state_t;

    // Data bits fill the non-power-of-2 codeword positions in order;
    // each Hamming bit i covers positions with bit i set.
    function automatic logic [ECC_WIDTH-1:0] ecc_enc(
        input logic [DATA_WIDTH-1:0] d
    );
        logic [ECC_WIDTH-1:0] e;
        logic                 b;
        int                   j;
        e = '0;
        j = 0;
        for (int p = 1; p < DATA_WIDTH + ECC_WIDTH; p++) begin
            if ((p & (p - 1)) != 0) begin
                b = |(d & (DATA_WIDTH'(1) << j));
                e = e ^ ({ECC_WIDTH{b}} & ECC_WIDTH'(p));
                j++;
            end
        end
        e[ECC_WIDTH-1] = ^{d, e[ECC_WIDTH-2:0]};
        return e;
    endfunction

    state_t                          state_q, state_d;
    logic                            req_q, req_d;
    logic [TW-1:0]                   tag_o_q, tag_o_d;
    logic [DATA_WIDTH+ECC_WIDTH-1:0] wdata_q, wdata_d;
    logic                            ovf_q, ovf_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic [PW-1:0]                   rd_q, rd_d;
    logic [PW-1:0]                   wr_q, wr_d;
    logic [PW-1:0]                   wr_q1;
    logic [DEPTH-1:0]                vld_q, vld_d;
    logic [TW-1:0]                   tag_q  [DEPTH];
    logic [DATA_WIDTH-1:0]           data_q [DEPTH];

    logic [TW-1:0]         lo_tag, hi_tag, st_tag;
    logic [DEPTH-1:0]      kill, vld_k;
    logic                  lo_ok, hi_ok;
    logic                  pop, want, offs;
    logic [CW-1:0]         free;
    logic                  acc_lo, acc_hi;
    logic                  acc0_v, acc1_v;
    logic [TW-1:0]         acc0_tag;
    logic [DATA_WIDTH-1:0] acc0_data;
    logic [PW-1:0]         nxt;
    logic                  src_vld;
    logic [TW-1:0]         src_tag;
    logic [DATA_WIDTH-1:0] src_data;
    logic                  unused_lsb;

    assign lo_tag = sec_lo_addr[ADDR_WIDTH-1:3];
    assign hi_tag = sec_hi_addr[ADDR_WIDTH-1:3];
    assign st_tag = stbuf_wr_addr[ADDR_WIDTH-1:3];
    assign wr_q1  = wr_q + PW'(1);

    assign unused_lsb = ^{sec_lo_addr[2:0], sec_hi_addr[2:0],
                          stbuf_wr_addr[2:0]};

    always_comb begin
        kill = '0;
        for (int i = 0; i < DEPTH; i++) begin
            kill[i] = stbuf_wr_valid && (tag_q[i] == st_tag);
        end
    end

    assign vld_k = vld_q & ~kill;

    assign lo_ok = sec_lo_valid && !ecc_disable &&
                   !(stbuf_wr_valid && lo_tag == st_tag);
    assign hi_ok = sec_hi_valid && !ecc_disable &&
                   !(stbuf_wr_valid && hi_tag == st_tag);

    always_comb begin
        pop  = 1'b0;
        want = 1'b0;
        offs = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cnt_q != '0 && !vld_k[rd_q]) begin
                    pop = 1'b1;
                end else begin
                    want = 1'b1;
                end
            end
            S_REQ: begin
                if (dccm_scrub_gnt) begin
                    pop  = 1'b1;
                    want = 1'b1;
                    offs = 1'b1;
                end else if (kill[rd_q]) begin
                    pop = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Free space already accounts for the slot released by this cycle's pop.
    always_comb begin
        free   = CW'(DEPTH) - cnt_q + CW'(pop);
        acc_lo = 1'b0;
        acc_hi = 1'b0;
        ovf_d  = 1'b0;
        if (lo_ok && hi_ok) begin
            if (free >= CW'(2)) begin
                acc_lo = 1'b1;
                acc_hi = 1'b1;
            end else if (free == CW'(1)) begin
                acc_lo = 1'b1;
                ovf_d  = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (lo_ok) begin
            acc_lo = (free != '0);
            ovf_d  = (free == '0);
        end else if (hi_ok) begin
            acc_hi = (free != '0);
            ovf_d  = (free == '0);
        end
    end

    assign acc0_v    = acc_lo | acc_hi;
    assign acc1_v    = acc_lo & acc_hi;
    assign acc0_tag  = acc_lo ? lo_tag : hi_tag;
    assign acc0_data = acc_lo ? sec_lo_data : sec_hi_data;

    // Entry to present next; falls through to this cycle's first push
    // when the queue holds nothing beyond the entry being retired.
    always_comb begin
        nxt      = rd_q + PW'(offs);
        src_vld  = acc0_v;
        src_tag  = acc0_tag;
        src_data = acc0_data;
        if (CW'(offs) < cnt_q) begin
            src_vld  = vld_k[nxt];
            src_tag  = tag_q[nxt];
            src_data = data_q[nxt];
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        tag_o_d = tag_o_q;
        wdata_d = wdata_q;
        if (ecc_disable) begin
            state_d = S_IDLE;
            req_d   = 1'b0;
        end else if (want && src_vld) begin
            state_d = S_REQ;
            req_d   = 1'b1;
            tag_o_d = src_tag;
            wdata_d = {ecc_enc(src_data), src_data};
        end else if (state_q == S_IDLE || pop) begin
            state_d = S_IDLE;
            req_d   = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q - CW'(pop) + CW'(acc0_v) + CW'(acc1_v);
        rd_d  = rd_q + PW'(pop);
        wr_d  = wr_q + PW'(acc0_v) + PW'(acc1_v);
        vld_d = vld_k;
        if (pop) begin
            vld_d[rd_q] = 1'b0;
        end
        if (acc0_v) begin
            vld_d[wr_q] = 1'b1;
        end
        if (acc1_v) begin
            vld_d[wr_q1] = 1'b1;
        end
        if (ecc_disable) begin
            cnt_d = '0;
            rd_d  = '0;
            wr_d  = '0;
            vld_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            tag_o_q <= '0;
            wdata_q <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            vld_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            tag_o_q <= tag_o_d;
            wdata_q <= wdata_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            vld_q   <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (acc0_v) begin
            tag_q[wr_q]  <= acc0_tag;
            data_q[wr_q] <= acc0_data;
        end
        if (acc1_v) begin
            tag_q[wr_q1]  <= hi_tag;
            data_q[wr_q1] <= sec_hi_data;
        end
    end

    assign dccm_scrub_req   = req_q;
    assign dccm_scrub_addr  = {tag_o_q, 3'b000};
    assign dccm_scrub_wdata = wdata_q;
    assign scrub_ovf        = ovf_q;
    assign scrub_busy       = (cnt_q != '0) | req_q;

endmodule

// File: tb/tb_lsu_ecc_scrub_wr.sv
// Directed bench for lsu_ecc_scrub_wr: encoder vectors from a table,
// then hand-written multi-cycle sequences.
module tb_lsu_ecc_scrub_wr;

    logic        clk = 1'b0;
    logic        rst;
    logic        sec_lo_valid, sec_hi_valid;
    logic [15:0] sec_lo_addr, sec_hi_addr;
    logic [63:0] sec_lo_data, sec_hi_data;
    logic        stbuf_wr_valid;
    logic [15:0] stbuf_wr_addr;
    logic        ecc_disable;
    logic        dccm_scrub_req;
    logic [15:0] dccm_scrub_addr;
    logic [71:0] dccm_scrub_wdata;
    logic        dccm_scrub_gnt;
    logic        scrub_ovf;
    logic        scrub_busy;

    int checks = 0;
    int errors = 0;

    lsu_ecc_scrub_wr dut (
        .clk              (clk),
        .rst              (rst),
        .sec_lo_valid     (sec_lo_valid),
        .sec_lo_addr      (sec_lo_addr),
        .sec_lo_data      (sec_lo_data),
        .sec_hi_valid     (sec_hi_valid),
        .sec_hi_addr      (sec_hi_addr),
        .sec_hi_data      (sec_hi_data),
        .stbuf_wr_valid   (stbuf_wr_valid),
        .stbuf_wr_addr    (stbuf_wr_addr),
        .ecc_disable      (ecc_disable),
        .dccm_scrub_req   (dccm_scrub_req),
        .dccm_scrub_addr  (dccm_scrub_addr),
        .dccm_scrub_wdata (dccm_scrub_wdata),
        .dccm_scrub_gnt   (dccm_scrub_gnt),
        .scrub_ovf        (scrub_ovf),
        .scrub_busy       (scrub_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        hi;
        logic [15:0] addr;
        logic [63:0] data;
        logic [15:0] exp_addr;
        logic [7:0]  exp_ecc;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string name, input logic [71:0] act,
                       input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_lo(input logic [15:0] a, input logic [63:0] d);
        sec_lo_valid = 1'b1;
        sec_lo_addr  = a;
        sec_lo_data  = d;
    endtask

    task automatic push_hi(input logic [15:0] a, input logic [63:0] d);
        sec_hi_valid = 1'b1;
        sec_hi_addr  = a;
        sec_hi_data  = d;
    endtask

    task automatic no_push();
        sec_lo_valid = 1'b0;
        sec_hi_valid = 1'b0;
    endtask

    logic [15:0] seen[$];
    logic [15:0] exp_drain[4];

    initial begin
        vt[0] = '{1'b0, 16'h0108, 64'h0, 16'h0108, 8'h00};
        vt[1] = '{1'b0, 16'h0108, 64'h1, 16'h0108, 8'h83};
        vt[2] = '{1'b1, 16'h0203, 64'h2, 16'h0200, 8'h85};
        vt[3] = '{1'b0, 16'h1010, 64'h8, 16'h1010, 8'h07};
        vt[4] = '{1'b0, 16'h2000, 64'h3, 16'h2000, 8'h06};
        vt[5] = '{1'b1, 16'hFFFF, 64'h8000_0000_0000_0000, 16'hFFF8, 8'hC7};
        exp_drain = '{16'h0300, 16'h0308, 16'h0310, 16'h0318};

        rst = 1'b1;
        no_push();
        sec_lo_addr    = '0;
        sec_hi_addr    = '0;
        sec_lo_data    = '0;
        sec_hi_data    = '0;
        stbuf_wr_valid = 1'b0;
        stbuf_wr_addr  = '0;
        ecc_disable    = 1'b0;
        dccm_scrub_gnt = 1'b0;
        step();
        step();
        chk("rst req", 72'(dccm_scrub_req), 72'h0);
        chk("rst addr", 72'(dccm_scrub_addr), 72'h0);
        chk("rst wdata", dccm_scrub_wdata, 72'h0);
        chk("rst ovf", 72'(scrub_ovf), 72'h0);
        chk("rst busy", 72'(scrub_busy), 72'h0);
        rst = 1'b0;
        step();

        for (int k = 0; k < 6; k++) begin
            if (vt[k].hi) push_hi(vt[k].addr, vt[k].data);
            else push_lo(vt[k].addr, vt[k].data);
            step();
            no_push();
            chk($sformatf("vec%0d req", k), 72'(dccm_scrub_req), 72'h1);
            chk($sformatf("vec%0d addr", k), 72'(dccm_scrub_addr),
                72'(vt[k].exp_addr));
            chk($sformatf("vec%0d wdata", k), dccm_scrub_wdata,
                {vt[k].exp_ecc, vt[k].data});
            dccm_scrub_gnt = 1'b1;
            step();
            dccm_scrub_gnt = 1'b0;
            chk($sformatf("vec%0d req off", k), 72'(dccm_scrub_req), 72'h0);
            chk($sformatf("vec%0d busy off", k), 72'(scrub_busy), 72'h0);
        end

        push_lo(16'h0040, 64'h1);
        push_hi(16'h0048, 64'h2);
        step();
        no_push();
        dccm_scrub_gnt = 1'b1;
        chk("b2b first req", 72'(dccm_scrub_req), 72'h1);
        chk("b2b first addr", 72'(dccm_scrub_addr), 72'h40);
        chk("b2b first wdata", dccm_scrub_wdata, {8'h83, 64'h1});
        step();
        chk("b2b second req", 72'(dccm_scrub_req), 72'h1);
        chk("b2b second addr", 72'(dccm_scrub_addr), 72'h48);
        chk("b2b second wdata", dccm_scrub_wdata, {8'h85, 64'h2});
        step();
        dccm_scrub_gnt = 1'b0;
        chk("b2b done req", 72'(dccm_scrub_req), 72'h0);
        chk("b2b done busy", 72'(scrub_busy), 72'h0);

        push_lo(16'h0700, 64'h9);
        step();
        no_push();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d req", c), 72'(dccm_scrub_req), 72'h1);
            chk($sformatf("bp%0d addr", c), 72'(dccm_scrub_addr), 72'h700);
            chk($sformatf("bp%0d wdata", c), dccm_scrub_wdata,
                {8'h84, 64'h9});
            step();
        end
        dccm_scrub_gnt = 1'b1;
        step();
        dccm_scrub_gnt = 1'b0;
        chk("bp done req", 72'(dccm_scrub_req), 72'h0);
        chk("bp done busy", 72'(scrub_busy), 72'h0);

        push_lo(16'h0300, 64'h0);
        push_hi(16'h0308, 64'h0);
        step();
        no_push();
        push_lo(16'h0310, 64'h0);
        step();
        no_push();
        push_lo(16'h0318, 64'h0);
        push_hi(16'h0320, 64'h0);
        chk("ovf before", 72'(scrub_ovf), 72'h0);
        step();
        no_push();
        chk("ovf pulse", 72'(scrub_ovf), 72'h1);
        chk("ovf head held", 72'(dccm_scrub_addr), 72'h300);
        step();
        chk("ovf pulse end", 72'(scrub_ovf), 72'h0);
        dccm_scrub_gnt = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (dccm_scrub_req) seen.push_back(dccm_scrub_addr);
            step();
        end
        dccm_scrub_gnt = 1'b0;
        chk("ovf drain count", 72'(seen.size()), 72'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < seen.size()) begin
                chk($sformatf("ovf drain%0d", i), 72'(seen[i]),
                    72'(exp_drain[i]));
            end
        end
        chk("ovf drain busy", 72'(scrub_busy), 72'h0);

        push_lo(16'h0080, 64'h5);
        step();
        no_push();
        chk("kill presented", 72'(dccm_scrub_addr), 72'h80);
        stbuf_wr_valid = 1'b1;
        stbuf_wr_addr  = 16'h0084;
        push_lo(16'h0080, 64'h5);
        step();
        no_push();
        stbuf_wr_valid = 1'b0;
        chk("kill req drop", 72'(dccm_scrub_req), 72'h0);
        chk("kill busy", 72'(scrub_busy), 72'h0);
        step();
        chk("kill no retry", 72'(dccm_scrub_req), 72'h0);

        push_lo(16'h0100, 64'h0);
        push_hi(16'h0108, 64'h0);
        step();
        no_push();
        stbuf_wr_valid = 1'b1;
        stbuf_wr_addr  = 16'h010C;
        step();
        stbuf_wr_valid = 1'b0;
        chk("hole head req", 72'(dccm_scrub_req), 72'h1);
        chk("hole head addr", 72'(dccm_scrub_addr), 72'h100);
        dccm_scrub_gnt = 1'b1;
        step();
        dccm_scrub_gnt = 1'b0;
        chk("hole skip req", 72'(dccm_scrub_req), 72'h0);
        chk("hole still busy", 72'(scrub_busy), 72'h1);
        step();
        chk("hole popped", 72'(scrub_busy), 72'h0);
        chk("hole no req", 72'(dccm_scrub_req), 72'h0);

        push_lo(16'h0500, 64'h1);
        step();
        no_push();
        chk("rst mid req", 72'(dccm_scrub_req), 72'h1);
        rst = 1'b1;
        #1;
        chk("rst async req", 72'(dccm_scrub_req), 72'h0);
        chk("rst async busy", 72'(scrub_busy), 72'h0);
        chk("rst async addr", 72'(dccm_scrub_addr), 72'h0);
        #2;
        rst = 1'b0;
        step();
        chk("rst no retry", 72'(dccm_scrub_req), 72'h0);

        push_lo(16'h0600, 64'h0);
        push_hi(16'h0608, 64'h0);
        step();
        no_push();
        chk("dis pre req", 72'(dccm_scrub_req), 72'h1);
        ecc_disable = 1'b1;
        step();
        ecc_disable = 1'b0;
        chk("dis req", 72'(dccm_scrub_req), 72'h0);
        chk("dis busy", 72'(scrub_busy), 72'h0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("dis quiet%0d", c), 72'(dccm_scrub_req), 72'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
